// File: rtl/piano_pkg.sv
// -----------------------------------------------------------------------------
// piano_pkg
// Shared constants and helpers for the polyphonic piano synthesizer.
//   BASE_CLKS_PER_PERIOD : full-period length in clk cycles (100 MHz) of each
//                          semitone C..B in the lowest reference octave.
//   base_clks_per_period : table lookup, key index folded modulo 12 so key
//                          banks wider than one octave still map to a note.
//   vmax                 : largest value of a volume field of the given width.
// -----------------------------------------------------------------------------
package piano_pkg;

   localparam int unsigned NUM_BASE_KEYS = 12;
   localparam int unsigned BASE_W        = 32;
   localparam int unsigned OCT_W         = 3;

   localparam logic [BASE_W-1:0] BASE_CLKS_PER_PERIOD [NUM_BASE_KEYS] = '{
      32'd3057805, 32'd2886184, 32'd2724194, 32'd2571298,
      32'd2426982, 32'd2290765, 32'd2162195, 32'd2040840,
      32'd1926296, 32'd1818182, 32'd1716135, 32'd1619816
   };

   function automatic logic [BASE_W-1:0] base_clks_per_period(input int unsigned key);
      logic [3:0] idx;
      idx = 4'(key % NUM_BASE_KEYS);
      return BASE_CLKS_PER_PERIOD[idx];
   endfunction

   function automatic int unsigned vmax(input int unsigned vol_bits);
      return (32'd1 << vol_bits) - 32'd1;
   endfunction

endpackage

// File: rtl/piano_voice.sv
// -----------------------------------------------------------------------------
// piano_voice
// One tone generator slot. While allocated it produces a square wave whose
// half-period is the key's base period shifted right by (octave+1); the
// half-period is recomputed at every toggle, so an octave change lands at the
// next edge of the wave without a phase reset.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   alloc_i       claim this voice for key_i (square starts high)
//   free_i        release this voice (square low, counter cleared)
//   key_i         key index to latch on allocation
//   octave_i      octave select 0..7
//   volume_i      current master volume
//   busy_o        voice is allocated
//   key_o         key currently held by this voice
//   square_o      square-wave output
//   amp_o         volume while square is high, else 0
// -----------------------------------------------------------------------------
module piano_voice
   import piano_pkg::*;
#(
   parameter int unsigned KEY_W    = 4,
   parameter int unsigned VOL_BITS = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                alloc_i,
   input  logic                free_i,
   input  logic [KEY_W-1:0]    key_i,
   input  logic [OCT_W-1:0]    octave_i,
   input  logic [VOL_BITS-1:0] volume_i,
   output logic                busy_o,
   output logic [KEY_W-1:0]    key_o,
   output logic                square_o,
   output logic [VOL_BITS-1:0] amp_o
);

   logic              busy_q, busy_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic [BASE_W-1:0] cnt_q, cnt_d;
   logic              sq_q, sq_d;

   logic [OCT_W:0]    shift;
   logic [BASE_W-1:0] alloc_half;
   logic [BASE_W-1:0] reload_half;

   always_comb begin
      shift       = {1'b0, octave_i} + (OCT_W + 1)'(1);
      alloc_half  = base_clks_per_period(32'(key_i)) >> shift;
      reload_half = base_clks_per_period(32'(key_q)) >> shift;

      busy_d = busy_q;
      key_d  = key_q;
      cnt_d  = cnt_q;
      sq_d   = sq_q;

      if (free_i) begin
         busy_d = 1'b0;
         cnt_d  = '0;
         sq_d   = 1'b0;
      end else if (alloc_i) begin
         busy_d = 1'b1;
         key_d  = key_i;
         cnt_d  = alloc_half;
         sq_d   = 1'b1;
      end else if (busy_q) begin
         // Counter holds the cycles left in the current half-period; the
         // toggle happens on the cycle it would reach zero.
         if (cnt_q <= BASE_W'(1)) begin
            cnt_d = reload_half;
            sq_d  = ~sq_q;
         end else begin
            cnt_d = cnt_q - BASE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q <= 1'b0;
         key_q  <= '0;
         cnt_q  <= '0;
         sq_q   <= 1'b0;
      end else begin
         busy_q <= busy_d;
         key_q  <= key_d;
         cnt_q  <= cnt_d;
         sq_q   <= sq_d;
      end
   end

   assign busy_o   = busy_q;
   assign key_o    = key_q;
   assign square_o = sq_q;
   assign amp_o    = sq_q ? volume_i : '0;

endmodule

// File: rtl/piano_poly_synth.sv
// -----------------------------------------------------------------------------
// piano_poly_synth
// Polyphonic square-wave piano: key edges queue in a pending mask, one pending
// key per cycle is assigned to the lowest free voice, voices are mixed and the
// mix drives a PWM open-drain audio pin.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   octave_num_i       octave select, picked up by voices at each reload
//   play_en_i          amplifier enable, also gates aud_pwm_o
//   piano_keys_i       level key-held flags
//   vol_up_i/vol_down_i volume step requests (rising-edge)
//   aud_sd_o           amplifier shutdown pin (= play_en_i)
//   aud_pwm_o          open-drain PWM: released (Z) for high, else driven 0
//   volume_monitor_o   current volume
//   active_voices_o    per-voice allocated flags
//   voice_drop_o       one-cycle pulse when a press found no free voice
// -----------------------------------------------------------------------------
module piano_poly_synth
   import piano_pkg::*;
#(
   parameter int unsigned NUM_KEYS   = 12,
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned VOL_BITS   = 4,
   parameter int unsigned PWM_BITS   = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [OCT_W-1:0]      octave_num_i,
   input  logic                  play_en_i,
   input  logic [NUM_KEYS-1:0]   piano_keys_i,
   input  logic                  vol_up_i,
   input  logic                  vol_down_i,
   output logic                  aud_sd_o,
   output wire                   aud_pwm_o,
   output logic [VOL_BITS-1:0]   volume_monitor_o,
   output logic [NUM_VOICES-1:0] active_voices_o,
   output logic                  voice_drop_o
);

   localparam int unsigned KEY_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int unsigned SUM_W     = $clog2(NUM_VOICES) + VOL_BITS;
   localparam int unsigned PWM_SHIFT = PWM_BITS - SUM_W;
   localparam logic [VOL_BITS-1:0] VMAX = VOL_BITS'(vmax(VOL_BITS));

   // registered state
   logic [NUM_KEYS-1:0]  keys_q;
   logic [NUM_KEYS-1:0]  pending_q, pending_d;
   logic                 drop_q, drop_d;
   logic                 vol_up_q, vol_dn_q;
   logic [VOL_BITS-1:0]  vol_q, vol_d;
   logic [PWM_BITS-1:0]  ramp_q, ramp_d;
   logic [PWM_BITS-1:0]  cmp_q, cmp_d;

   // voice bank signals
   logic [NUM_VOICES-1:0]               vbusy;
   logic [NUM_VOICES-1:0][KEY_W-1:0]    vkey;
   logic [NUM_VOICES-1:0]               vsq;
   logic [NUM_VOICES-1:0][VOL_BITS-1:0] vamp;
   logic [NUM_VOICES-1:0]               voice_free;
   logic [NUM_VOICES-1:0]               voice_alloc;

   // allocator
   logic [NUM_KEYS-1:0]   key_rise, key_fall, cand;
   logic                  sel_valid;
   logic [KEY_W-1:0]      sel_key;
   logic                  sel_held;
   logic [NUM_VOICES-1:0] idle_v, free_oh;

   always_comb begin
      key_rise = piano_keys_i & ~keys_q;
      key_fall = ~piano_keys_i & keys_q;

      // A released key frees every voice holding it in the same cycle.
      voice_free = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         voice_free[v] = vbusy[v] & key_fall[vkey[v]];
      end

      // Service works from last cycle's pending mask, so a fresh press waits
      // one cycle; a key releasing right now is not serviced.
      cand      = pending_q & ~key_fall;
      sel_valid = 1'b0;
      sel_key   = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (cand[k]) begin
            sel_valid = 1'b1;
            sel_key   = KEY_W'(k);
         end
      end

      sel_held = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (vbusy[v] && !voice_free[v] && (vkey[v] == sel_key)) begin
            sel_held = 1'b1;
         end
      end

      // Free means idle at the start of the cycle; voices being released
      // now still read as busy and only become available next cycle.
      idle_v  = ~vbusy;
      free_oh = idle_v & (~idle_v + NUM_VOICES'(1));

      voice_alloc = '0;
      drop_d      = 1'b0;
      if (sel_valid && !sel_held) begin
         if (|free_oh) begin
            voice_alloc = free_oh;
         end else begin
            drop_d = 1'b1;
         end
      end

      pending_d = (pending_q | key_rise) & ~key_fall;
      if (sel_valid) begin
         pending_d[sel_key] = 1'b0;
      end
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : gen_voice
      piano_voice #(
         .KEY_W    (KEY_W),
         .VOL_BITS (VOL_BITS)
      ) u_voice (
         .clk      (clk),
         .resetn   (resetn),
         .alloc_i  (voice_alloc[v]),
         .free_i   (voice_free[v]),
         .key_i    (sel_key),
         .octave_i (octave_num_i),
         .volume_i (vol_q),
         .busy_o   (vbusy[v]),
         .key_o    (vkey[v]),
         .square_o (vsq[v]),
         .amp_o    (vamp[v])
      );
   end

   // volume, mixer and PWM
   logic             up_edge, dn_edge;
   logic [SUM_W-1:0] mix_sum;
   logic             pwm_high;

   always_comb begin
      up_edge = vol_up_i & ~vol_up_q;
      dn_edge = vol_down_i & ~vol_dn_q;
      vol_d   = vol_q;
      if (up_edge) begin
         if (vol_q != VMAX) vol_d = vol_q + VOL_BITS'(1);
      end else if (dn_edge) begin
         if (vol_q != '0) vol_d = vol_q - VOL_BITS'(1);
      end

      mix_sum = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         mix_sum = mix_sum + (vsq[v] ? SUM_W'(vamp[v]) : '0);
      end

      // Duty only changes at the ramp wrap, so a period is never cut short.
      ramp_d = ramp_q + PWM_BITS'(1);
      cmp_d  = cmp_q;
      if (&ramp_q) begin
         cmp_d = PWM_BITS'(mix_sum) << PWM_SHIFT;
      end

      pwm_high = (ramp_q < cmp_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         keys_q    <= '0;
         pending_q <= '0;
         drop_q    <= 1'b0;
         vol_up_q  <= 1'b0;
         vol_dn_q  <= 1'b0;
         vol_q     <= '0;
         ramp_q    <= '0;
         cmp_q     <= '0;
      end else begin
         keys_q    <= piano_keys_i;
         pending_q <= pending_d;
         drop_q    <= drop_d;
         vol_up_q  <= vol_up_i;
         vol_dn_q  <= vol_down_i;
         vol_q     <= vol_d;
         ramp_q    <= ramp_d;
         cmp_q     <= cmp_d;
      end
   end

   assign aud_sd_o         = play_en_i;
   assign aud_pwm_o        = (pwm_high && play_en_i) ? 1'bz : 1'b0;
   assign volume_monitor_o = vol_q;
   assign active_voices_o  = vbusy;
   assign voice_drop_o     = drop_q;

endmodule

// File: doc/piano_poly_synth.md
PIANO_POLY_SYNTH -- requirements
Module: piano_poly_synth

Interface
REQ-001 Parameter NUM_KEYS, default 12, number of key inputs; key 0 = C, ascending semitones.
REQ-002 Parameter NUM_VOICES, default 4, simultaneous sounding notes (1..8).
REQ-003 Parameter VOL_BITS, default 4, volume width; VMAX = 2^VOL_BITS-1.
REQ-004 Parameter PWM_BITS, default 8, PWM ramp width; PWM period = 2^PWM_BITS clk.
REQ-005 clk  input  1  system clock, 100 MHz.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 octave_num  input  3  octave select 0..7, sampled at each voice half-period reload.
REQ-008 play_en  input  1  amplifier enable; also gates aud_pwm.
REQ-009 piano_keys  input  NUM_KEYS  level key-held flags, synchronous to clk.
REQ-010 vol_up / vol_down  input  1 each  volume step requests, rising-edge sensitive.
REQ-011 aud_sd  output  1  equals play_en combinationally.
REQ-012 aud_pwm  output  1  open-drain: high-Z when PWM high and play_en=1, else driven 0.
REQ-013 volume_monitor  output  VOL_BITS  current volume.
REQ-014 active_voices  output  NUM_VOICES  bit v = 1 while voice v is allocated.
REQ-015 voice_drop  output  1  one-cycle pulse when a key press finds no free voice.

Function
REQ-016 Key press = rising edge of piano_keys[k] versus registered copy; sets pending[k].
REQ-017 Each cycle, the lowest-index pending key is serviced: allocated to the lowest-index free voice, pending bit cleared; one allocation per cycle maximum.
REQ-018 Pending key with no free voice: pending bit cleared, voice_drop pulses that cycle, key never sounds.
REQ-019 Key falling edge: every voice holding that key frees the same cycle (parallel); pending bit for that key cleared.
REQ-020 Release and allocation in the same cycle: a voice freed this cycle is not allocatable until the next cycle.
REQ-021 A key already held by a voice cannot be allocated a second voice.
REQ-022 Voice half-period = BASE_CLKS_PER_PERIOD[key] >> (octave_num+1), reloaded on each toggle; octave change takes effect at next reload, no phase reset.
REQ-023 On allocation the voice counter loads immediately and its square output starts at 1.
REQ-024 Free voice: square output 0, counter held at 0.
REQ-025 Mix sum = sum over voices of (square ? volume : 0), width clog2(NUM_VOICES)+VOL_BITS, no overflow possible.
REQ-026 PWM duty compare = mix sum left-shifted to PWM_BITS (truncated from MSB side never; PWM_BITS >= sum width); PWM high while ramp < compare; ramp free-runs and wraps 2^PWM_BITS-1 -> 0.
REQ-027 Compare value updates only at ramp wrap (glitch-free duty).
REQ-028 Volume: rising edge of vol_up increments, of vol_down decrements; saturates at VMAX and 0; both edges same cycle -> increment only.
REQ-029 play_en=0: aud_pwm driven 0; voices, ramp and allocation continue running.
REQ-030 Volume 0 or no active voices: aud_pwm constantly driven 0.

Reset
REQ-031 Asserted resetn: volume=0, all voices free, pending=0, key/vol edge registers=0, ramp=0, compare=0, voice_drop=0, aud_pwm driven 0.
REQ-032 Reset mid-note silences immediately (asynchronous); keys still held at deassertion are treated as new presses on the first clock edge.

Structure
REQ-033 Package piano_pkg holds BASE_CLKS_PER_PERIOD (32-bit per key, C..B: 3057805, 2886184, 2724194, 2571298, 2426982, 2290765, 2162195, 2040840, 1926296, 1818182, 1716135, 1619816), width constants and VMAX function.
REQ-034 Sub-module piano_voice (allocate/free, key index, octave, volume in; square and amplitude out) instantiated NUM_VOICES times; allocator, volume and PWM stay in top.

Verification
REQ-035 Press key 9 (A), octave 4, volume 8: voice 0 allocated, square half-period 56818 clk, active_voices=0001.
REQ-036 Press keys 0,4,7,11 same cycle then key 2: voices 0..3 hold 0,4,7,11 on four consecutive cycles; key 2 -> voice_drop pulse, no allocation.
REQ-037 Release key 4 and press key 2 same cycle: voice 1 frees; key 2 allocated to voice 1 one cycle later.
REQ-038 16 vol_up edges from 0 -> volume_monitor=15; simultaneous up/down at 15 -> stays 15; 20 vol_down -> 0.
REQ-039 Two voices high, volume 15, PWM_BITS=8: compare=120 -> aud_pwm high-Z 120 of 256 clk; play_en=0 -> driven 0, aud_sd=0.
REQ-040 Assert resetn low mid-note: aud_pwm driven 0 same cycle, all outputs at reset values; deassert with key held -> re-allocated to voice 0.
